// File: rtl/dmem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_responder_pkg;

    localparam int XLEN_DEF = 32;

    // Access size encodings on req_size_i; 2'd3 is illegal
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unshifted byte-enable mask for an access size (lane 0 based)
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    size_mask = 4'b0001;
            SZ_H:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word SRAM with per-byte write enables and a registered read.
module dmem_sram_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // One access per enabled edge: byte-masked write, or read into rdata
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store slave: captures one request, runs it against the SRAM on the
// first BUSY edge, and presents the response LATENCY edges after acceptance.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter int              DEPTH_WORDS = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int              LATENCY     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic            cap_we;
    logic [1:0]      cap_size;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;

    logic            accept;
    logic            first_busy;
    logic            last_busy;
    logic [XLEN-1:0] offset;
    logic [1:0]      lane;
    logic            err;
    logic [31:0]     sram_q;

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == RESP);
    assign accept       = req_valid_i & req_ready_o;
    assign first_busy   = (state == BUSY) && (cnt == '0);
    assign last_busy    = (state == BUSY) && (cnt == CNT_LAST);

    // BASE_ADDR is word aligned, so the offset's low bits are the byte lane
    assign offset = cap_addr - BASE_ADDR;
    assign lane   = offset[1:0];

    // Error decode on the captured request
    always_comb begin
        err = 1'b0;
        if (cap_size == 2'd3)                        err = 1'b1;
        if ((cap_size == SZ_H) && cap_addr[0])       err = 1'b1;
        if ((cap_size == SZ_W) && |cap_addr[1:0])    err = 1'b1;
        if (cap_addr < BASE_ADDR)                    err = 1'b1;
        if (|offset[XLEN-1:IDX_W+2])                 err = 1'b1;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: accept -> wait out the latency -> hold until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = BUSY;
            BUSY:    if (last_busy)    state_nxt = RESP;
            RESP:    if (resp_ready_i) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Latency counter, only advances while BUSY
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              cnt <= '0;
        else if (state != BUSY) cnt <= '0;
        else if (last_busy)     cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end

    // Request capture on the accept edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_we    <= 1'b0;
            cap_size  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_we    <= req_we_i;
            cap_size  <= req_size_i;
            cap_addr  <= req_addr_i;
            cap_wdata <= req_wdata_i;
        end
    end

    // SRAM is touched exactly once, on the first BUSY edge; read data then
    // sits in its output register until the response is formed
    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk   (clk_i),
        .en    (first_busy & ~err),
        .we    (cap_we),
        .be    (size_mask(cap_size) << lane),
        .addr  (offset[IDX_W+1:2]),
        .wdata (cap_wdata << {lane, 3'b000}),
        .rdata (sram_q)
    );

    // Response registers load on entry to RESP and hold until taken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else if (last_busy) begin
            resp_rdata_o <= (err | cap_we) ? '0 : (sram_q >> {lane, 3'b000});
            resp_err_o   <= err;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-level model.
module tb_dmem_responder;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT   = 2;

    logic        clk_i, rst_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [31:0] resp_rdata_o;

    dmem_responder #(
        .XLEN (32), .DEPTH_WORDS (DEPTH), .BASE_ADDR (BASE), .LATENCY (LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_size_i   (req_size_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        time         t_acc;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mem [logic [31:0]];
    int          checks, errors;
    logic        hold, done, mon_seen;

    // Requester-side response acceptance: random, or forced low during holds
    initial begin
        resp_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            resp_ready_i = hold ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compute the expected response from the byte model, apply stores to the
    // model, then drive the request until it is accepted
    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic        bad;
        logic [31:0] wa, w;
        int          n;
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
              || (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
        e.err   = bad;
        e.rdata = 32'h0;
        if (!bad) begin
            if (we) begin
                for (int i = 0; i < (1 << sz); i++) mem[a + i] = wd[8*i +: 8];
            end else begin
                wa = {a[31:2], 2'b00};
                w  = {mem[wa + 3], mem[wa + 2], mem[wa + 1], mem[wa]};
                e.rdata = w >> (8 * a[1:0]);
            end
        end
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_size_i  = sz;
        req_addr_i  = a;
        req_wdata_i = wd;
        n = 0;
        while (!req_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk_i);
        e.t_acc = $time;
        sbq.push_back(e);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !req_ready_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain", 32'(n < 200), 32'd1);
    endtask

    initial begin
        logic [31:0] a, old;
        logic [1:0]  sz;
        int          r, n;
        checks = 0; errors = 0;
        hold = 1'b0; done = 1'b0; mon_seen = 1'b0;
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
        req_addr_i = 32'h0; req_wdata_i = 32'h0;
        repeat (2) @(negedge clk_i);
        chk("rst_req_ready",  32'(req_ready_o),  32'd1);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_rdata",      resp_rdata_o,      32'd0);
        chk("rst_err",        32'(resp_err_o),   32'd0);
        rst_i = 1'b0;

        fork
            begin : driver
                // Prefill the window used by random traffic and the top word
                for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, BASE + 4 * i, $urandom);
                issue(1'b1, 2'd2, BASE + 4 * DEPTH - 4, 32'hCAFE_F00D);

                issue(1'b1, 2'd2, BASE, 32'hDEAD_BEEF);
                issue(1'b0, 2'd2, BASE, 32'h0);

                issue(1'b1, 2'd0, BASE + 5, 32'h0000_00AA);
                issue(1'b0, 2'd2, BASE + 4, 32'h0);
                issue(1'b0, 2'd0, BASE + 5, 32'h0);

                issue(1'b1, 2'd1, BASE + 1, 32'h0000_1234);
                issue(1'b0, 2'd2, BASE, 32'h0);
                issue(1'b0, 2'd3, BASE + 8, 32'h0);
                issue(1'b1, 2'd3, BASE + 8, 32'h5555_5555);
                issue(1'b0, 2'd2, BASE + 8, 32'h0);

                issue(1'b0, 2'd2, BASE + 4 * DEPTH, 32'h0);
                issue(1'b0, 2'd2, 32'h7FFF_FFFC, 32'h0);
                issue(1'b0, 2'd2, BASE + 4 * DEPTH - 4, 32'h0);
                wait_idle();

                // Stall the response; a competing request must not be taken
                hold = 1'b1;
                issue(1'b0, 2'd2, BASE + 8, 32'h0);
                n = 0;
                while (!resp_valid_o && n < 20) begin
                    @(negedge clk_i);
                    n++;
                end
                chk("hold_resp_seen", 32'(resp_valid_o), 32'd1);
                for (int i = 0; i < 5; i++) begin
                    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2;
                    req_addr_i  = BASE + 8; req_wdata_i = 32'h1234_5678;
                    @(negedge clk_i);
                    chk("hold_req_ready", 32'(req_ready_o), 32'd0);
                end
                req_valid_i = 1'b0;
                hold = 1'b0;
                wait_idle();
                issue(1'b0, 2'd2, BASE + 8, 32'h0);
                wait_idle();

                // Reset after the commit edge: store survives, no response
                issue(1'b1, 2'd2, BASE + 12, 32'hA5A5_0F0F);
                @(posedge clk_i);
                #1;
                rst_i = 1'b1;
                sbq.delete();
                mon_seen = 1'b0;
                repeat (2) begin
                    @(negedge clk_i);
                    chk("rst_mid_valid", 32'(resp_valid_o), 32'd0);
                    chk("rst_mid_ready", 32'(req_ready_o),  32'd1);
                end
                rst_i = 1'b0;
                issue(1'b0, 2'd2, BASE + 12, 32'h0);
                wait_idle();

                // Reset before the commit edge: store is dropped
                old = {mem[BASE + 19], mem[BASE + 18], mem[BASE + 17], mem[BASE + 16]};
                issue(1'b1, 2'd2, BASE + 16, ~old);
                rst_i = 1'b1;
                sbq.delete();
                mon_seen = 1'b0;
                for (int i = 0; i < 4; i++) mem[BASE + 16 + i] = old[8*i +: 8];
                @(negedge clk_i);
                chk("rst_early_valid", 32'(resp_valid_o), 32'd0);
                rst_i = 1'b0;
                issue(1'b0, 2'd2, BASE + 16, 32'h0);
                wait_idle();

                // Random traffic
                for (int k = 0; k < 200; k++) begin
                    r = $urandom_range(15);
                    if (r == 0)      a = BASE - 4 * $urandom_range(1, 4);
                    else if (r == 1) a = BASE + 4 * DEPTH + $urandom_range(0, 15);
                    else             a = BASE + $urandom_range(0, 63);
                    sz = 2'($urandom_range(3));
                    issue(1'($urandom_range(1)), sz, a, $urandom);
                end
                wait_idle();
                done = 1'b1;
            end
            begin : monitor
                while (!done) begin
                    @(negedge clk_i);
                    if (!rst_i && resp_valid_o) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_resp", 32'(resp_valid_o), 32'd0);
                        end else begin
                            if (!mon_seen) begin
                                mon_seen = 1'b1;
                                chk("latency", 32'(($time - sbq[0].t_acc - 5) / 10), 32'(LAT));
                            end
                            chk("rdata", resp_rdata_o,     sbq[0].rdata);
                            chk("err",   32'(resp_err_o),  32'(sbq[0].err));
                            if (resp_ready_i) begin
                                void'(sbq.pop_front());
                                mon_seen = 1'b0;
                            end
                        end
                    end
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
